ex_mem_pipe: RTL

EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

---
 rtl/ex_mem_pipe.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register built as a 2-entry skid buffer with branch resolution.
// Define EX_MEM_FWD_EN to add the head-entry forwarding outputs.
module ex_mem_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_zero_i,
    input  logic [31:0] rt_data_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        reg_write_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic        mem_to_reg_i,
    input  logic        branch_i,
    input  logic [31:0] pc_branch_i,
    input  logic        flush_i,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic [31:0] alu_result_o,
    output logic [31:0] rt_data_o,
    output logic [4:0]  rd_addr_o,
    output logic        reg_write_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        mem_to_reg_o,
    output logic        branch_taken_o,
    output logic [31:0] branch_target_o
`ifdef EX_MEM_FWD_EN
    ,
    output logic        fwd_valid_o,
    output logic [4:0]  fwd_rd_o,
    output logic [31:0] fwd_data_o
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] rt_data;
        logic [4:0]  rd_addr;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
    } entry_t;

    localparam entry_t ENTRY_CLR = entry_t'({$bits(entry_t){1'b0}});

    // Writes to r0 are architecturally dead, so drop the write enable here.
    function automatic entry_t capture(
        input logic [31:0] alu_result,
        input logic [31:0] rt_data,
        input logic [4:0]  rd_addr,
        input logic        reg_write,
        input logic        mem_read,
        input logic        mem_write,
        input logic        mem_to_reg
    );
        entry_t e;
        e.alu_result = alu_result;
        e.rt_data    = rt_data;
        e.rd_addr    = rd_addr;
        e.reg_write  = reg_write && (rd_addr != 5'd0);
        e.mem_read   = mem_read;
        e.mem_write  = mem_write;
        e.mem_to_reg = mem_to_reg;
        return e;
    endfunction

    state_t      state_r;
    entry_t      head_r;
    entry_t      skid_r;
    entry_t      in_s;
    logic        push_s;
    logic        pop_s;
    logic        taken_s;
    logic        branch_taken_r;
    logic [31:0] branch_target_r;

    assign ex_ready_o  = (state_r != FULL) && !rst;
    assign mem_valid_o = (state_r != EMPTY);
    assign push_s      = ex_valid_i && ex_ready_o;
    assign pop_s       = mem_valid_o && mem_ready_i;
    assign taken_s     = push_s && branch_i && alu_zero_i;
    assign in_s        = capture(alu_result_i, rt_data_i, rd_addr_i, reg_write_i,
                                 mem_read_i, mem_write_i, mem_to_reg_i);

    // Buffer occupancy, entry storage and branch pulse registers.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            state_r         <= EMPTY;
            head_r          <= ENTRY_CLR;
            skid_r          <= ENTRY_CLR;
            branch_taken_r  <= 1'b0;
            branch_target_r <= 32'd0;
        end else begin
            // The branch resolves at acceptance, independent of later stalls.
            branch_taken_r  <= taken_s;
            branch_target_r <= taken_s ? pc_branch_i : 32'd0;
            case (state_r)
                EMPTY: begin
                    if (push_s) begin
                        head_r  <= in_s;
                        state_r <= ONE;
                    end else begin
                        state_r <= EMPTY;
                    end
                end
                ONE: begin
                    case ({push_s, pop_s})
                        2'b10: begin
                            skid_r  <= in_s;
                            state_r <= FULL;
                        end
                        2'b01: begin
                            head_r  <= ENTRY_CLR;
                            state_r <= EMPTY;
                        end
                        2'b11: begin
                            head_r  <= in_s;
                            state_r <= ONE;
                        end
                        default: state_r <= ONE;
                    endcase
                end
                FULL: begin
                    if (pop_s) begin
                        head_r  <= skid_r;
                        skid_r  <= ENTRY_CLR;
                        state_r <= ONE;
                    end else begin
                        state_r <= FULL;
                    end
                end
                default: begin
                    head_r  <= ENTRY_CLR;
                    skid_r  <= ENTRY_CLR;
                    state_r <= EMPTY;
                end
            endcase
        end
    end

    // Head payload is forced to zero whenever no beat is presented.
    always_comb begin
        alu_result_o = 32'd0;
        rt_data_o    = 32'd0;
        rd_addr_o    = 5'd0;
        reg_write_o  = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        if (mem_valid_o) begin
            alu_result_o = head_r.alu_result;
            rt_data_o    = head_r.rt_data;
            rd_addr_o    = head_r.rd_addr;
            reg_write_o  = head_r.reg_write;
            mem_read_o   = head_r.mem_read;
            mem_write_o  = head_r.mem_write;
            mem_to_reg_o = head_r.mem_to_reg;
        end else begin
            alu_result_o = 32'd0;
        end
    end

    assign branch_taken_o  = branch_taken_r;
    assign branch_target_o = branch_target_r;

`ifdef EX_MEM_FWD_EN
    // Forwarding view of the head entry for the hazard unit.
    always_comb begin
        fwd_valid_o = mem_valid_o && reg_write_o;
        fwd_rd_o    = 5'd0;
        fwd_data_o  = 32'd0;
        if (fwd_valid_o) begin
            fwd_rd_o   = head_r.rd_addr;
            fwd_data_o = head_r.alu_result;
        end else begin
            fwd_rd_o   = 5'd0;
        end
    end
`endif

endmodule
